// File: rtl/bcd_display.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// driving a bank of active-low seven-segment digits from a held display register.
module bcd_display #(
  parameter int WIDTH       = 6,
  parameter int DIGITS      = 2,
  parameter bit BLANK_ZEROS = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      in,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 4 * DIGITS;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CONV = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic             flag_q, flag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    disp_q, disp_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [AW-1:0]    corr;
  logic [AW-1:0]    acc_next;
  logic [WIDTH-1:0] shift_next;
  logic             carry;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h40;
      4'd1:    seg_of = 7'h79;
      4'd2:    seg_of = 7'h24;
      4'd3:    seg_of = 7'h30;
      4'd4:    seg_of = 7'h19;
      4'd5:    seg_of = 7'h12;
      4'd6:    seg_of = 7'h02;
      4'd7:    seg_of = 7'h78;
      4'd8:    seg_of = 7'h00;
      4'd9:    seg_of = 7'h10;
      default: seg_of = 7'h7F;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    // Digits are corrected independently; the carry out of the top digit is the overflow bit.
    corr = acc_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) begin
        corr[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
    end
    {acc_next, shift_next} = {corr[AW-2:0], shift_q, 1'b0};
    carry = corr[AW-1];

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CONV;
          shift_d = in;
          acc_d   = '0;
          flag_d  = 1'b0;
          cnt_d   = CW'(WIDTH);
        end
      end
      CONV: begin
        acc_d   = acc_next;
        shift_d = shift_next;
        flag_d  = flag_q | carry;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          disp_d  = acc_next;
          ovf_d   = flag_q | carry;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  logic [3:0] digit;
  logic       nz_above;

  // Walk from the top digit down so blanking knows whether anything higher was nonzero.
  always_comb begin
    hex      = '0;
    digit    = '0;
    nz_above = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      digit    = disp_q[4*k +: 4];
      nz_above = nz_above | (digit != 4'd0);
      if (ovf_q) begin
        hex[7*k +: 7] = 7'h3F;
      end else if (BLANK_ZEROS && (k > 0) && !nz_above) begin
        hex[7*k +: 7] = 7'h7F;
      end else begin
        hex[7*k +: 7] = seg_of(digit);
      end
    end
  end

  assign busy = (state_q == CONV);
  assign done = done_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bcd_display.sv
// Scoreboard bench for bcd_display: unit 0 is WIDTH=7/DIGITS=2 without blanking,
// unit 1 is WIDTH=8/DIGITS=3 with leading-zero blanking.
module tb_bcd_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s[2];
  logic [7:0]  in_s[2];
  logic        busy_a, done_a, ovf_a;
  logic        busy_b, done_b, ovf_b;
  logic [13:0] hex_a;
  logic [20:0] hex_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [20:0] hex;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [20:0] last_hex[2];
  logic        last_ovf[2];

  bcd_display #(.WIDTH(7), .DIGITS(2), .BLANK_ZEROS(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .in(in_s[0][6:0]),
    .busy(busy_a), .done(done_a), .ovf(ovf_a), .hex(hex_a)
  );

  bcd_display #(.WIDTH(8), .DIGITS(3), .BLANK_ZEROS(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .in(in_s[1]),
    .busy(busy_b), .done(done_b), .ovf(ovf_b), .hex(hex_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wid(input int u);
    return (u == 0) ? 7 : 8;
  endfunction

  // Reference: decimal digits by division, overflow by comparison with 10^DIGITS.
  function automatic void model(input int u, input int value, output logic [20:0] h, output logic o);
    logic [6:0] tbl[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int d = (u == 0) ? 2 : 3;
    bit blank = (u == 1);
    int p = 1;
    h = '0;
    o = (value >= 10 ** d);
    for (int k = 0; k < d; k++) begin
      if (o) h[7*k +: 7] = 7'h3F;
      else if (blank && k > 0 && value < p) h[7*k +: 7] = 7'h7F;
      else h[7*k +: 7] = tbl[(value / p) % 10];
      p = p * 10;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int u, input int value);
    exp_t e;
    model(u, value, e.hex, e.ovf);
    e.due = cyc + wid(u) + 1;
    if (u == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic check_output(input int u, input logic [20:0] h, input logic o, input logic b);
    exp_t e;
    if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
      check(u == 0 ? "unexpected_done_a" : "unexpected_done_b", 32'd1, 32'd0);
    end else begin
      e = (u == 0) ? q0.pop_front() : q1.pop_front();
      check(u == 0 ? "hex_a" : "hex_b", 32'(h), 32'(e.hex));
      check(u == 0 ? "ovf_a" : "ovf_b", 32'(o), 32'(e.ovf));
      check(u == 0 ? "latency_a" : "latency_b", 32'(cyc), 32'(e.due));
      check(u == 0 ? "busy_at_done_a" : "busy_at_done_b", 32'(b), 32'd0);
      last_hex[u] = e.hex;
      last_ovf[u] = e.ovf;
    end
  endtask

  // Monitor: results on done, otherwise the display must hold its last value.
  always @(negedge clk) begin
    if (done_a) check_output(0, {7'h0, hex_a}, ovf_a, busy_a);
    else begin
      check("hold_hex_a", 32'(hex_a), 32'(last_hex[0]));
      check("hold_ovf_a", 32'(ovf_a), 32'(last_ovf[0]));
    end
    if (done_b) check_output(1, hex_b, ovf_b, busy_b);
    else begin
      check("hold_hex_b", 32'(hex_b), 32'(last_hex[1]));
      check("hold_ovf_b", 32'(ovf_b), 32'(last_ovf[1]));
    end
  end

  // mode 0: plain pulse; 1: extra start mid-conversion (ignored); 2: start held into done cycle.
  task automatic apply_stimulus(input int u, input int value, input int mode, input int value2);
    int w = wid(u);
    @(negedge clk);
    start_s[u] = 1'b1;
    in_s[u]    = 8'(value);
    push(u, value);
    @(negedge clk);
    check(u == 0 ? "busy_after_accept_a" : "busy_after_accept_b",
          32'(u == 0 ? busy_a : busy_b), 32'd1);
    if (mode == 2) begin
      in_s[u] = 8'(value2);
      repeat (w) @(negedge clk);
      push(u, value2);
      @(negedge clk);
      start_s[u] = 1'b0;
      in_s[u]    = 8'($urandom);
      repeat (w - 1) @(negedge clk);
    end else begin
      start_s[u] = 1'b0;
      in_s[u]    = 8'($urandom);
      if (mode == 1) begin
        @(negedge clk);
        start_s[u] = 1'b1;
        in_s[u]    = 8'(value2);
        @(negedge clk);
        start_s[u] = 1'b0;
        repeat (w - 3) @(negedge clk);
      end else begin
        repeat (w - 1) @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [20:0] h0;
    logic        o0;
    rst_n      = 1'b0;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    in_s[0]    = '0;
    in_s[1]    = '0;
    for (int u = 0; u < 2; u++) begin
      model(u, 0, h0, o0);
      last_hex[u] = h0;
      last_ovf[u] = o0;
    end
    repeat (2) @(negedge clk);
    check("reset_hex_a", 32'(hex_a), 32'h2040);
    check("reset_hex_b", 32'(hex_b), 32'h1FFFC0);
    check("reset_busy_a", 32'(busy_a), 32'd0);
    check("reset_done_a", 32'(done_a), 32'd0);
    check("reset_ovf_a", 32'(ovf_a), 32'd0);
    #1 rst_n = 1'b1;

    apply_stimulus(0, 63, 0, 0);
    apply_stimulus(0, 100, 0, 0);
    apply_stimulus(0, 99, 0, 0);
    apply_stimulus(0, 55, 1, 12);
    apply_stimulus(0, 17, 2, 88);
    apply_stimulus(0, 127, 0, 0);

    // Abort a conversion of 42 after its third iteration.
    @(negedge clk);
    start_s[0] = 1'b1;
    in_s[0]    = 8'd42;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      model(u, 0, h0, o0);
      last_hex[u] = h0;
      last_ovf[u] = o0;
    end
    @(negedge clk);
    check("abort_busy_a", 32'(busy_a), 32'd0);
    check("abort_hex_a", 32'(hex_a), 32'h2040);
    #1 rst_n = 1'b1;
    apply_stimulus(0, 42, 0, 0);

    apply_stimulus(1, 5, 0, 0);
    apply_stimulus(1, 0, 0, 0);
    apply_stimulus(1, 207, 0, 0);
    apply_stimulus(1, 10, 2, 255);
    apply_stimulus(1, 100, 1, 3);

    for (int i = 0; i < 20; i++) begin
      apply_stimulus(0, int'($urandom_range(0, 127)), int'($urandom_range(0, 2)), int'($urandom_range(0, 127)));
    end
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 2)), int'($urandom_range(0, 255)));
    end

    repeat (12) @(negedge clk);
    check("pending_a", 32'(q0.size()), 32'd0);
    check("pending_b", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_display.md
# bcd_display

Sequential binary-to-decimal display driver for the seven-segment bank. It converts a `WIDTH`-bit unsigned value into `DIGITS` BCD digits using iterative shift-and-add-3 (one bit per clock). It then drives `DIGITS` active-low seven-segment digits from a held display register. It replaces the per-value combinational converter/decoder pairs on the board, handles arbitrary width and digit count, and adds overflow indication and optional leading-zero blanking.

## Interface
- `WIDTH`, 6: input value width in bits, ≥1.
- `DIGITS`, 2: number of decimal digits / seven-segment displays, ≥1.
- `BLANK_ZEROS`, 0: 1 = blank leading zero digits. The ones digit is never blanked.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request conversion of `in`; sampled only in IDLE.
- `in`  in  WIDTH  unsigned binary value, captured on the accepting edge.
- `busy`  out  1  high while converting.
- `done`  out  1  one-cycle pulse when the display register updates.
- `ovf`  out  1  last conversion had value ≥ 10^DIGITS; held until next update.
- `hex`  out  7*DIGITS  segments; digit k at `hex[7k+6:7k]`, k=0 is ones. Bit 0 = a … bit 6 = g, active-low.

One clock; reset is asynchronous and active-low (`clk`, `rst_n`).

## Operation
- States: IDLE, CONV.
- IDLE, `start`=1:
  - shift register ← `in`
  - BCD accumulator (4*DIGITS bits) ← 0
  - overflow flag ← 0
  - bit counter ← WIDTH
  - go to CONV.
- CONV, each cycle:
  - every accumulator digit ≥5 gets +3, no carry between digits;
  - then {accumulator, shift register} shift left by 1;
  - the bit shifted out of the top accumulator digit ORs into the overflow flag;
  - counter decrements.
- Last iteration (counter = 1):
  - display register ← corrected/shifted accumulator;
  - `ovf` ← final overflow flag;
  - `done` = 1 next cycle;
  - return to IDLE.
- `start` while in CONV is ignored, not queued.
- Decoder, combinational from the display register, active-low:
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
- `ovf`=1: every digit shows dash 0x3F, regardless of `BLANK_ZEROS`.
- `BLANK_ZEROS`=1, no ovf: digit k>0 is blanked (0x7F) iff it and all higher digits are 0.
- If WIDTH bits cannot reach 10^DIGITS, `ovf` is constant 0.

## Timing
- Reset (async):
  - state IDLE, `busy`=0, `done`=0, `ovf`=0;
  - display register = 0, so `hex` shows 0x40 on all digits, or 0x40 on ones and 0x7F elsewhere when `BLANK_ZEROS`=1.
- Reset during CONV aborts the conversion; the display returns to its reset value.
- `start` sampled at edge E0 in IDLE:
  - `busy`=1 from after E0 until after E_WIDTH;
  - iterations occur on edges E1..E_WIDTH;
  - `hex`/`ovf` change and `done`=1 right after E_WIDTH, for exactly one cycle.
- Latency is WIDTH+1 edges from accepting edge to new display. Throughput is one conversion per WIDTH+1 cycles.
- `start` high in the `done` cycle is accepted (state is IDLE), so back-to-back operation has no gap.
- `in` may change after the accepting edge without effect.
- `hex` is glitch-free across conversions: it changes only on the update edge.

## Test plan
- Reset, defaults (WIDTH=6, DIGITS=2, BLANK_ZEROS=0) -> `hex`=0x40 on both digits (14'h2040), `busy`=0, `done`=0, `ovf`=0.
- `in`=63, `start` pulse -> `busy` for 6 cycles, `done` 7 edges after acceptance; `hex[6:0]`=0x30 (3), `hex[13:7]`=0x02 (6), `ovf`=0.
- WIDTH=7, DIGITS=2, `in`=100 -> `ovf`=1, both digits 0x3F. Then `in`=99 -> `ovf`=0, both digits 0x10.
- BLANK_ZEROS=1, DIGITS=3, WIDTH=8:
  - `in`=5 -> digits (ones..hundreds) 0x12, 0x7F, 0x7F;
  - `in`=0 -> 0x40, 0x7F, 0x7F;
  - `in`=207 -> 0x78, 0x40, 0x24.
- `start` re-asserted mid-CONV with a different `in` -> ignored, first result displayed. `start` held high through `done` -> second conversion accepted on the `done` cycle, second `done` 7 cycles later.
- `rst_n` pulsed low at iteration 3 of a conversion of 42 -> immediate IDLE, display at reset value, no `done`. The next conversion of 42 shows 0x24 (2) and 0x19 (4).
